// File: rtl/adder_err_pkg.sv
// Shared types and width helpers for the approximate-adder error sweep.
// Accumulator widths are chosen so no metric can wrap over a full 2^(2W) sweep.
package adder_err_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  function automatic int cnt_w(input int w);
    return 2 * w + 1;
  endfunction

  function automatic int sae_w(input int w);
    return 3 * w + 1;
  endfunction

endpackage

// File: rtl/adder_err_accum.sv
// One-deep stage register followed by |dut - exact| and the three error accumulators.
// A captured vector is accumulated on the edge after capture; clr wipes stage and metrics.
module adder_err_accum
  import adder_err_pkg::*;
#(
  parameter int W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  cap_vld,
  input  logic [W:0]            exact,
  input  logic [W:0]            dut_sum,
  output logic [cnt_w(W)-1:0]   err_cnt,
  output logic [W:0]            max_ae,
  output logic [sae_w(W)-1:0]   sum_ae
);

  localparam int CW = cnt_w(W);
  localparam int SW = sae_w(W);

  logic            stg_vld_q;
  logic [W:0]      stg_exact_q;
  logic [W:0]      stg_sum_q;
  logic [CW-1:0]   err_cnt_q;
  logic [W:0]      max_ae_q;
  logic [SW-1:0]   sum_ae_q;
  logic [W:0]      ae_d;

  always_comb begin
    ae_d = (stg_sum_q >= stg_exact_q) ? (stg_sum_q - stg_exact_q)
                                      : (stg_exact_q - stg_sum_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      stg_vld_q   <= 1'b0;
      stg_exact_q <= '0;
      stg_sum_q   <= '0;
      err_cnt_q   <= '0;
      max_ae_q    <= '0;
      sum_ae_q    <= '0;
    end else begin
      stg_vld_q   <= cap_vld;
      stg_exact_q <= exact;
      stg_sum_q   <= dut_sum;
      if (stg_vld_q) begin
        err_cnt_q <= err_cnt_q + {{(CW-1){1'b0}}, (ae_d != '0)};
        sum_ae_q  <= sum_ae_q + {{(SW-W-1){1'b0}}, ae_d};
        if (ae_d > max_ae_q) max_ae_q <= ae_d;
      end
    end
  end

  assign err_cnt = err_cnt_q;
  assign max_ae  = max_ae_q;
  assign sum_ae  = sum_ae_q;

endmodule

// File: rtl/adder_err_sweep_ctrl.sv
// Exhaustive error sweep of an external combinational W-bit adder over all 2^(2W) operand pairs.
// done pulses in the cycle after edge E(N+1) from the accept edge; each hold cycle in RUN adds one.
module adder_err_sweep_ctrl
  import adder_err_pkg::*;
#(
  parameter int W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hold,
  output logic [W-1:0]          op_a,
  output logic [W-1:0]          op_b,
  input  logic [W:0]            dut_sum,
  output logic                  busy,
  output logic                  done,
  output logic [cnt_w(W)-1:0]   err_cnt,
  output logic [W:0]            max_ae,
  output logic [sae_w(W)-1:0]   sum_ae
);

  state_e          state_q;
  logic [2*W-1:0]  cnt_q;
  logic [2*W-1:0]  cnt_d;
  logic            busy_q;
  logic            done_q;
  logic            accept;
  logic            cap_vld;
  logic [W:0]      exact;

  assign accept  = start && (state_q == IDLE || state_q == DONE);
  assign cap_vld = (state_q == RUN) && !hold;
  assign cnt_d   = cnt_q + 1'b1;
  assign op_a    = cnt_q[W-1:0];
  assign op_b    = cnt_q[2*W-1:W];
  assign exact   = {1'b0, op_a} + {1'b0, op_b};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!hold) begin
            // counter wraps to 0 on the last capture, so operands read 0 afterwards
            cnt_q <= cnt_d;
            if (cnt_q == '1) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          if (accept) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  adder_err_accum #(.W(W)) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .cap_vld (cap_vld),
    .exact   (exact),
    .dut_sum (dut_sum),
    .err_cnt (err_cnt),
    .max_ae  (max_ae),
    .sum_ae  (sum_ae)
  );

endmodule

// File: tb/tb_adder_err_sweep_ctrl.sv
// Bench for the adder error sweep controller: models three adder variants and scoreboards
// expected metrics and done latency per sweep.
module tb_adder_err_sweep_ctrl;

  localparam int W = 6;
  localparam int N = 1 << (2 * W);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic [W:0]        dut_sum;
  logic              busy;
  logic              done;
  logic [2*W:0]      err_cnt;
  logic [W:0]        max_ae;
  logic [3*W:0]      sum_ae;

  int dut_mode = 0;
  int cyc = 0;
  int e0 = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*W:0] err;
    logic [W:0]   mx;
    logic [3*W:0] sm;
    int           lat;
  } exp_t;
  exp_t sb[$];

  // mode 0: exact, 1: sum[0] forced 0, 2: carry-out forced 0
  function automatic logic [W:0] model_dut(input int mode, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (mode == 1) s[0] = 1'b0;
    if (mode == 2) s[W] = 1'b0;
    return s;
  endfunction

  assign dut_sum = model_dut(dut_mode, op_a, op_b);

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  adder_err_sweep_ctrl #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .hold    (hold),
    .op_a    (op_a),
    .op_b    (op_b),
    .dut_sum (dut_sum),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .max_ae  (max_ae),
    .sum_ae  (sum_ae)
  );

  task automatic push_exp(input int mode, input int hold_len);
    exp_t e;
    int ec, mx, sm, ex, ds, ae;
    ec = 0; mx = 0; sm = 0;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        ex = a + b;
        ds = int'(model_dut(mode, W'(a), W'(b)));
        ae = (ds > ex) ? ds - ex : ex - ds;
        if (ae != 0) ec++;
        if (ae > mx) mx = ae;
        sm += ae;
      end
    end
    e.err = (2*W+1)'(ec);
    e.mx  = (W+1)'(mx);
    e.sm  = (3*W+1)'(sm);
    e.lat = N + 1 + hold_len;
    sb.push_back(e);
  endtask

  task automatic start_sweep(input int mode, input int hold_len);
    dut_mode = mode;
    @(negedge clk) start = 1'b1;
    push_exp(mode, hold_len);
    @(negedge clk) start = 1'b0;
    e0 = cyc;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL accept_busy got %0b want 1", busy);
    end
  endtask

  // Runs until done; optional hold window, spurious start, and restart in the done cycle.
  task automatic run_to_done(input int hold_at, input int hold_len, input int spur_at, input bit restart);
    exp_t e;
    int held;
    bit seen;
    int idx;
    held = 0; seen = 1'b0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      @(negedge clk);
      idx = int'({op_b, op_a});
      if (done === 1'b1) begin
        seen = 1'b1;
        hold = 1'b0;
        start = restart;
        if (sb.size() == 0) begin
          errors++; $display("FAIL scoreboard_empty at done");
        end else begin
          e = sb.pop_front();
          checks++;
          if (cyc - e0 !== e.lat) begin
            errors++; $display("FAIL latency got %0d want %0d", cyc - e0, e.lat);
          end
          checks++;
          if (err_cnt !== e.err) begin
            errors++; $display("FAIL err_cnt got %0d want %0d", err_cnt, e.err);
          end
          checks++;
          if (max_ae !== e.mx) begin
            errors++; $display("FAIL max_ae got %0d want %0d", max_ae, e.mx);
          end
          checks++;
          if (sum_ae !== e.sm) begin
            errors++; $display("FAIL sum_ae got %0d want %0d", sum_ae, e.sm);
          end
        end
      end else begin
        if (busy && hold_len > 0 && idx == hold_at && held < hold_len) begin
          hold = 1'b1; held++;
        end else begin
          hold = 1'b0;
        end
        start = (busy && idx == spur_at);
      end
    end
    if (!seen) begin
      errors++; $display("FAIL done_timeout no done within budget");
      hold = 1'b0; start = 1'b0;
    end
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || op_a !== '0 || op_b !== '0) begin
      errors++;
      $display("FAIL %s_post got done=%0b busy=%0b a=%0d b=%0d want 0 0 0 0", tag, done, busy, op_a, op_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || op_a !== '0 || op_b !== '0 ||
        err_cnt !== '0 || max_ae !== '0 || sum_ae !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%0b done=%0b a=%0d b=%0d err=%0d max=%0d sum=%0d want all 0",
               busy, done, op_a, op_b, err_cnt, max_ae, sum_ae);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_exact();
    start_sweep(0, 0);
    run_to_done(-1, 0, -1, 1'b0);
    check_idle_after("exact");
  endtask

  task automatic test_lsb();
    start_sweep(1, 0);
    run_to_done(-1, 0, -1, 1'b0);
    check_idle_after("lsb");
  endtask

  task automatic test_carry();
    start_sweep(2, 0);
    run_to_done(-1, 0, -1, 1'b0);
    check_idle_after("carry");
  endtask

  task automatic test_hold();
    start_sweep(1, 10);
    run_to_done(1000, 10, -1, 1'b0);
    check_idle_after("hold");
  endtask

  task automatic test_reset_midsweep();
    bit hit;
    int prev;
    hit = 1'b0;
    start_sweep(1, 0);
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clk);
      prev = int'({op_b, op_a});
      if (prev == 500) begin
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if (busy !== 1'b1 || int'({op_b, op_a}) !== 501) begin
          errors++; $display("FAIL spurious_start got busy=%0b idx=%0d want 1 501", busy, {op_b, op_a});
        end
      end else if (prev == 2000) begin
        hit = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      errors++; $display("FAIL midsweep_reach got no vector 2000 want reached");
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || op_a !== '0 || op_b !== '0 ||
        err_cnt !== '0 || max_ae !== '0 || sum_ae !== '0) begin
      errors++;
      $display("FAIL midsweep_reset got busy=%0b a=%0d b=%0d err=%0d max=%0d sum=%0d want all 0",
               busy, op_a, op_b, err_cnt, max_ae, sum_ae);
    end
    rst_n = 1'b1;
    void'(sb.pop_front());
    start_sweep(0, 0);
    run_to_done(-1, 0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_sweep(2, 0);
    run_to_done(-1, 0, -1, 1'b1);
    push_exp(2, 0);
    @(negedge clk) start = 1'b0;
    e0 = cyc;
    checks++;
    if (busy !== 1'b1 || err_cnt !== '0 || max_ae !== '0 || sum_ae !== '0) begin
      errors++;
      $display("FAIL restart_clear got busy=%0b err=%0d max=%0d sum=%0d want 1 0 0 0",
               busy, err_cnt, max_ae, sum_ae);
    end
    run_to_done(-1, 0, -1, 1'b0);
    check_idle_after("b2b");
  endtask

  initial begin
    test_reset();
    test_exact();
    test_lsb();
    test_carry();
    test_hold();
    test_reset_midsweep();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
